// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: requester and full_adder-cell signals of serial_add_ctrl.
// Carries the sub input only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum_out;
   logic             cout_out;
   logic             fa_in1;
   logic             fa_in2;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   modport master (
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      output start, a, b, cin, fa_sum, fa_cout,
      input  busy, done, sum_out, cout_out, fa_in1, fa_in2, fa_cin
   );

   modport slave (
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin, fa_sum, fa_cout,
      output busy, done, sum_out, cout_out, fa_in1, fa_in2, fa_cin
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder driving one shared external full_adder cell.
// SERIAL_ADD_SUB_EN adds a sub input (b inverted, carry forced to 1 -> a - b).
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run, last, load;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;

`ifdef SERIAL_ADD_SUB_EN
   assign b_ld = bus.sub ? ~bus.b : bus.b;
   assign c_ld = bus.sub | bus.cin;
`else
   assign b_ld = bus.b;
   assign c_ld = bus.cin;
`endif

   assign run  = state_q == RUN;
   assign last = cnt_q == CW'(WIDTH - 1);
   // start is honoured in IDLE and DONE, which gives back-to-back jobs
   assign load = !run && bus.start;

   always_comb begin
      state_d = load ? RUN : run ? (last ? DONE : RUN) : IDLE;
      a_d     = load ? bus.a : run ? a_q >> 1 : a_q;
      b_d     = load ? b_ld : run ? b_q >> 1 : b_q;
      carry_d = load ? c_ld : run ? bus.fa_cout : carry_q;
      cnt_d   = load ? '0 : (run && !last) ? cnt_q + CW'(1) : cnt_q;
      res_d   = load ? '0 : run ? {bus.fa_sum, res_q[WIDTH-1:1]} : res_q;
      sum_d   = (run && last) ? {bus.fa_sum, res_q[WIDTH-1:1]} : sum_q;
      cout_d  = (run && last) ? bus.fa_cout : cout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy     = run;
   assign bus.done     = state_q == DONE;
   assign bus.sum_out  = sum_q;
   assign bus.cout_out = cout_q;
   assign bus.fa_in1   = run & a_q[0];
   assign bus.fa_in2   = run & b_q[0];
   assign bus.fa_cin   = run & carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random jobs checked against a + b + cin arithmetic.
// Exercises subtraction too when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   logic [W:0] last_res = '0;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(W)) ifc ();
   serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

   // the shared full_adder cell
   assign ifc.fa_sum  = ifc.fa_in1 ^ ifc.fa_in2 ^ ifc.fa_cin;
   assign ifc.fa_cout = (ifc.fa_in1 & ifc.fa_in2) | (ifc.fa_in1 & ifc.fa_cin) | (ifc.fa_in2 & ifc.fa_cin);

   always @(posedge clk) if (ifc.done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
      if (s) return {x >= y, W'(x - y)};
      return {1'b0, x} + {1'b0, y} + (W+1)'(c);
   endfunction

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
      @(negedge clk);
      ifc.a = x;
      ifc.b = y;
      ifc.cin = c;
`ifdef SERIAL_ADD_SUB_EN
      ifc.sub = s;
`else
      if (s) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic finish_job(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s,
                             input int n0, input bit b2b, input string tag);
      int n = n0;
      logic [W:0] r = model(x, y, c, s);
      chk({tag, "_hold"}, {ifc.cout_out, ifc.sum_out}, last_res);
      while (ifc.done !== 1'b1 && n < 4 * W) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, W + 1);
      chk({tag, "_sum"}, ifc.sum_out, r[W-1:0]);
      chk({tag, "_cout"}, ifc.cout_out, r[W]);
      chk({tag, "_busy_dn"}, ifc.busy, 0);
      last_res = r;
      if (b2b) begin
         ifc.a = 8'h01;
         ifc.b = 8'h02;
         ifc.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         ifc.sub = 1'b0;
`endif
         ifc.start = 1'b1;
         @(negedge clk);
         ifc.start = 1'b0;
         chk({tag, "_b2b_busy"}, ifc.busy, 1);
         chk({tag, "_b2b_done"}, ifc.done, 0);
      end else begin
         @(negedge clk);
         chk({tag, "_pulse"}, ifc.done, 0);
         chk({tag, "_held"}, {ifc.cout_out, ifc.sum_out}, r);
      end
   endtask

   initial begin
      int d0;
      logic [W-1:0] x, y;
      logic c, s;
      ifc.start = 1'b0;
      ifc.a = '0;
      ifc.b = '0;
      ifc.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ifc.sub = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_res", {ifc.cout_out, ifc.sum_out}, 0);
      chk("rst_fa", {ifc.fa_in1, ifc.fa_in2, ifc.fa_cin}, 0);
      rst_n = 1'b1;

      d0 = done_cnt;
      launch(8'h25, 8'h5A, 1'b0, 1'b0);
      chk("t1_busy", ifc.busy, 1);
      chk("t1_fa", {ifc.fa_in1, ifc.fa_in2, ifc.fa_cin}, 3'b100);
      finish_job(8'h25, 8'h5A, 1'b0, 1'b0, 1, 1'b0, "t1");
      chk("t1_sum_k", ifc.sum_out, 8'h7F);
      chk("t1_ndone", done_cnt - d0, 1);

      launch(8'hFF, 8'h01, 1'b0, 1'b0);
      finish_job(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b0, "t2");
      chk("t2_k", {ifc.cout_out, ifc.sum_out}, 9'h100);
      launch(8'hFF, 8'hFF, 1'b1, 1'b0);
      finish_job(8'hFF, 8'hFF, 1'b1, 1'b0, 1, 1'b0, "t3");
      chk("t3_k", {ifc.cout_out, ifc.sum_out}, 9'h1FF);

      d0 = done_cnt;
      launch(8'h81, 8'h7E, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      ifc.a = '0;
      ifc.b = '0;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      chk("t4_busy", ifc.busy, 1);
      finish_job(8'h81, 8'h7E, 1'b1, 1'b0, 5, 1'b0, "t4");
      chk("t4_ndone", done_cnt - d0, 1);

      d0 = done_cnt;
      launch(8'h10, 8'h20, 1'b0, 1'b0);
      finish_job(8'h10, 8'h20, 1'b0, 1'b0, 1, 1'b1, "t5a");
      finish_job(8'h01, 8'h02, 1'b0, 1'b0, 1, 1'b0, "t5b");
      chk("t5_ndone", done_cnt - d0, 2);
      chk("t5_sum_k", ifc.sum_out, 8'h03);

      launch(8'h33, 8'h44, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t6_hold", ifc.sum_out, 8'h03);
      d0 = done_cnt;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_busy", ifc.busy, 0);
      chk("t6_done", ifc.done, 0);
      chk("t6_res", {ifc.cout_out, ifc.sum_out}, 0);
      chk("t6_fa", {ifc.fa_in1, ifc.fa_in2, ifc.fa_cin}, 0);
      repeat (12) @(negedge clk);
      chk("t6_ndone", done_cnt - d0, 0);
      rst_n = 1'b1;
      last_res = '0;
      launch(8'h12, 8'h34, 1'b1, 1'b0);
      finish_job(8'h12, 8'h34, 1'b1, 1'b0, 1, 1'b0, "t6f");

      for (int i = 0; i < 40; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         launch(x, y, c, s);
         finish_job(x, y, c, s, 1, 1'b0, "rnd");
      end

`ifdef SERIAL_ADD_SUB_EN
      launch(8'h10, 8'h01, 1'b0, 1'b1);
      finish_job(8'h10, 8'h01, 1'b0, 1'b1, 1, 1'b0, "sub1");
      chk("sub1_k", {ifc.cout_out, ifc.sum_out}, 9'h10F);
      launch(8'h01, 8'h02, 1'b1, 1'b1);
      finish_job(8'h01, 8'h02, 1'b1, 1'b1, 1, 1'b0, "sub2");
      chk("sub2_k", {ifc.cout_out, ifc.sum_out}, 9'h0FF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
